// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, NZCV flag indices and the condition evaluator
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, res;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_eval_lane.sv
// rtl/cond_eval_lane.sv - one query channel: ready term, evaluation, registered result
// Per-channel pass/fail counters are present only when COND_PERF_EN is defined.
module cond_eval_lane
    import cond_pkg::*;
`ifdef COND_PERF_EN
#(
    parameter int PERF_W = 16
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       q_valid,
    input  logic [3:0] q_cond,
    input  logic [3:0] eff_flags,
    input  logic       pend_free,
    output logic       q_ready,
    output logic       r_valid,
    output logic       r_pass
`ifdef COND_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_pass,
    output logic [PERF_W-1:0] perf_fail
`endif
);

    logic pass_now;
    logic accept;

    // AL and NV never depend on flags, so they bypass the pending check
    assign q_ready  = (q_cond == COND_AL) || (q_cond == COND_NV) || pend_free;
    assign pass_now = cond_eval(q_cond, eff_flags);
    assign accept   = q_valid & q_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_valid <= accept;
            if (accept) begin
                r_pass <= pass_now;
            end
        end
    end

`ifdef COND_PERF_EN
    // Counting on accept makes the new count visible together with r_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_pass <= '0;
            perf_fail <= '0;
        end else if (accept) begin
            if (pass_now && (perf_pass != '1)) begin
                perf_pass <= perf_pass + PERF_W'(1);
            end
            if (!pass_now && (perf_fail != '1)) begin
                perf_fail <= perf_fail + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/cond_status_unit.sv
// rtl/cond_status_unit.sv - NZCV status register, pending-setter counter and condition query channels
// Optional per-channel pass/fail performance counters are enabled by COND_PERF_EN.
module cond_status_unit
    import cond_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int MAX_PEND = 3,
`ifdef COND_PERF_EN
    parameter int PERF_W   = 16,
`endif
    localparam int CNT_W   = $clog2(MAX_PEND + 1)
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                claim_i,
    input  logic                upd_en_i,
    input  logic [3:0]          upd_flags_i,
    input  logic                flush_i,
    input  logic [NUM_CH-1:0]   q_valid_i,
    input  logic [4*NUM_CH-1:0] q_cond_i,
    output logic [NUM_CH-1:0]   q_ready_o,
    output logic [NUM_CH-1:0]   r_valid_o,
    output logic [NUM_CH-1:0]   r_pass_o,
    output logic [3:0]          flags_o,
    output logic [CNT_W-1:0]    pend_cnt_o,
    output logic                pend_full_o,
    output logic                err_o
`ifdef COND_PERF_EN
    ,
    output logic [PERF_W*NUM_CH-1:0] perf_pass_o,
    output logic [PERF_W*NUM_CH-1:0] perf_fail_o
`endif
);

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] pend_q;
    logic             err_q;
    logic [3:0]       eff_flags;
    logic             pend_free;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (pend_q == CNT_W'(MAX_PEND));
    assign at_zero = (pend_q == '0);

    // A writeback retiring the last pending setter resolves flags this cycle,
    // unless a new setter is claimed alongside it.
    assign pend_free = at_zero || ((pend_q == CNT_W'(1)) && upd_en_i && !claim_i);
    assign eff_flags = upd_en_i ? upd_flags_i : flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (upd_en_i) begin
            flags_q <= upd_flags_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else if (flush_i) begin
            pend_q <= '0;
        end else if (claim_i && !upd_en_i) begin
            if (at_max) begin
                err_q <= 1'b1;
            end else begin
                pend_q <= pend_q + CNT_W'(1);
            end
        end else if (upd_en_i && !claim_i) begin
            if (at_zero) begin
                err_q <= 1'b1;
            end else begin
                pend_q <= pend_q - CNT_W'(1);
            end
        end
    end

    assign flags_o     = flags_q;
    assign pend_cnt_o  = pend_q;
    assign pend_full_o = at_max;
    assign err_o       = err_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        cond_eval_lane
`ifdef COND_PERF_EN
        #(
            .PERF_W(PERF_W)
        )
`endif
        u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .q_valid   (q_valid_i[k]),
            .q_cond    (q_cond_i[4*k +: 4]),
            .eff_flags (eff_flags),
            .pend_free (pend_free),
            .q_ready   (q_ready_o[k]),
            .r_valid   (r_valid_o[k]),
            .r_pass    (r_pass_o[k])
`ifdef COND_PERF_EN
            ,
            .perf_pass (perf_pass_o[PERF_W*k +: PERF_W]),
            .perf_fail (perf_fail_o[PERF_W*k +: PERF_W])
`endif
        );
    end

endmodule

// File: tb/tb_cond_status_unit.sv
// tb/tb_cond_status_unit.sv - vector table, corner sequences and randomized model check for cond_status_unit
module tb_cond_status_unit;

    localparam int MAX_PEND = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       claim_i, upd_en_i, flush_i;
    logic [3:0] upd_flags_i;
    logic [1:0] q_valid_i;
    logic [7:0] q_cond_i;
    logic [1:0] q_ready_o, r_valid_o, r_pass_o;
    logic [3:0] flags_o;
    logic [1:0] pend_cnt_o;
    logic       pend_full_o, err_o;
`ifdef COND_PERF_EN
    logic [31:0] perf_pass_o, perf_fail_o;
`endif

    always #5 clk = ~clk;

    cond_status_unit #(
        .NUM_CH   (2),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .claim_i     (claim_i),
        .upd_en_i    (upd_en_i),
        .upd_flags_i (upd_flags_i),
        .flush_i     (flush_i),
        .q_valid_i   (q_valid_i),
        .q_cond_i    (q_cond_i),
        .q_ready_o   (q_ready_o),
        .r_valid_o   (r_valid_o),
        .r_pass_o    (r_pass_o),
        .flags_o     (flags_o),
        .pend_cnt_o  (pend_cnt_o),
        .pend_full_o (pend_full_o),
        .err_o       (err_o)
`ifdef COND_PERF_EN
        ,
        .perf_pass_o (perf_pass_o),
        .perf_fail_o (perf_fail_o)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: even codes test a base predicate, odd codes invert it
    function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    int         m_cnt;
    logic [3:0] m_flags;
    bit         m_err;
    logic [1:0] m_rpass;

    task automatic model_reset();
        m_cnt = 0; m_flags = 4'b0000; m_err = 1'b0; m_rpass = 2'b00;
    endtask

    task automatic model_cycle(input bit cl, input bit up, input bit fl, input logic [3:0] uf,
                               input logic [1:0] qv, input logic [7:0] qc,
                               output logic [1:0] rdy, output logic [1:0] rv);
        logic [3:0] eff, c;
        eff = up ? uf : m_flags;
        for (int k = 0; k < 2; k++) begin
            c = qc[4*k +: 4];
            rdy[k] = (c >= 4'd14) || (m_cnt == 0) || (m_cnt == 1 && up && !cl);
            rv[k]  = qv[k] && rdy[k];
            if (rv[k]) m_rpass[k] = ref_pass(c, eff);
        end
        if (up) m_flags = uf;
        if (fl) m_cnt = 0;
        else if (cl && !up) begin
            if (m_cnt == MAX_PEND) m_err = 1'b1; else m_cnt++;
        end else if (up && !cl) begin
            if (m_cnt == 0) m_err = 1'b1; else m_cnt--;
        end
    endtask

    task automatic drive(input bit cl, input bit up, input bit fl, input logic [3:0] uf,
                         input logic [1:0] qv, input logic [7:0] qc);
        claim_i = cl; upd_en_i = up; flush_i = fl; upd_flags_i = uf;
        q_valid_i = qv; q_cond_i = qc;
    endtask

    // Entered and left at a falling edge
    task automatic cycle_check(input string tag, input bit cl, input bit up, input bit fl,
                               input logic [3:0] uf, input logic [1:0] qv, input logic [7:0] qc,
                               input logic [1:0] e_rdy, input logic [1:0] e_rv, input logic [1:0] e_rp,
                               input logic [3:0] e_flags, input int e_cnt, input bit e_err);
        drive(cl, up, fl, uf, qv, qc);
        #1;
        chk({tag, ".ready"}, 32'(q_ready_o), 32'(e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".r_valid"}, 32'(r_valid_o), 32'(e_rv));
        chk({tag, ".r_pass"}, 32'(r_pass_o), 32'(e_rp));
        chk({tag, ".flags"}, 32'(flags_o), 32'(e_flags));
        chk({tag, ".pend_cnt"}, 32'(pend_cnt_o), 32'(e_cnt));
        chk({tag, ".pend_full"}, 32'(pend_full_o), 32'(e_cnt == MAX_PEND));
        chk({tag, ".err"}, 32'(err_o), 32'(e_err));
        @(negedge clk);
    endtask

    task automatic model_check(input string tag, input bit cl, input bit up, input bit fl,
                               input logic [3:0] uf, input logic [1:0] qv, input logic [7:0] qc);
        logic [1:0] rdy, rv;
        model_cycle(cl, up, fl, uf, qv, qc, rdy, rv);
        cycle_check(tag, cl, up, fl, uf, qv, qc, rdy, rv, m_rpass, m_flags, m_cnt, m_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         cl, up, fl;
        logic [3:0] uf;
        logic [1:0] qv;
        logic [7:0] qc;
        logic [1:0] rdy, rv, rp;
        logic [3:0] fo;
        int         cnt;
        bit         err;
    } vec_t;

    function automatic vec_t mk(input bit cl, input bit up, input bit fl, input logic [3:0] uf,
                                input logic [1:0] qv, input logic [7:0] qc, input logic [1:0] rdy,
                                input logic [1:0] rv, input logic [1:0] rp, input logic [3:0] fo,
                                input int cnt, input bit err);
        vec_t t;
        t.cl = cl; t.up = up; t.fl = fl; t.uf = uf; t.qv = qv; t.qc = qc;
        t.rdy = rdy; t.rv = rv; t.rp = rp; t.fo = fo; t.cnt = cnt; t.err = err;
        return t;
    endfunction

    vec_t tbl[17];
    int   pc[2];

    initial begin
        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 4'b0100, 2'b01, 8'h00, 2'b11, 2'b01, 2'b01, 4'b0100, 0, 1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00, 2'b11, 2'b00, 2'b01, 4'b0100, 1, 1'b1);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00, 2'b00, 2'b00, 2'b01, 4'b0100, 2, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'b01, 8'h0A, 2'b00, 2'b00, 2'b01, 4'b0100, 2, 1'b1);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 4'b0110, 2'b01, 8'h0A, 2'b00, 2'b00, 2'b01, 4'b0110, 1, 1'b1);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 4'b1001, 2'b01, 8'h0A, 2'b11, 2'b01, 2'b01, 4'b1001, 0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'b01, 8'h0B, 2'b11, 2'b01, 2'b00, 4'b1001, 0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 4'b1001, 1, 1'b1);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'b1001, 2, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'b10, 8'hE0, 2'b10, 2'b10, 2'b10, 4'b1001, 2, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'b10, 8'hF0, 2'b10, 2'b10, 2'b00, 4'b1001, 2, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 4'b0010, 2'b11, 8'h22, 2'b00, 2'b00, 2'b00, 4'b0010, 2, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'b0010, 3, 1'b1);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'b0010, 3, 1'b1);
        tbl[14] = mk(1'b1, 1'b1, 1'b1, 4'b1100, 2'b11, 8'hE0, 2'b10, 2'b10, 2'b10, 4'b1100, 0, 1'b1);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 4'b0011, 2'b11, 8'h76, 2'b11, 2'b11, 2'b01, 4'b0011, 0, 1'b1);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'b11, 8'h98, 2'b11, 2'b11, 2'b01, 4'b0011, 0, 1'b1);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h00);
        #1;
        chk("reset.flags", 32'(flags_o), 32'h0);
        chk("reset.pend_cnt", 32'(pend_cnt_o), 32'h0);
        chk("reset.r_valid", 32'(r_valid_o), 32'h0);
        chk("reset.r_pass", 32'(r_pass_o), 32'h0);
        chk("reset.err", 32'(err_o), 32'h0);
        chk("reset.pend_full", 32'(pend_full_o), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            cycle_check($sformatf("vec%0d", i), tbl[i].cl, tbl[i].up, tbl[i].fl, tbl[i].uf,
                        tbl[i].qv, tbl[i].qc, tbl[i].rdy, tbl[i].rv, tbl[i].rp, tbl[i].fo,
                        tbl[i].cnt, tbl[i].err);

        // Reset asserted mid-cycle with a query in flight
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 2'b01, 8'h0E);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.r_valid", 32'(r_valid_o), 32'h0);
        chk("midrst.r_pass", 32'(r_pass_o), 32'h0);
        chk("midrst.flags", 32'(flags_o), 32'h0);
        chk("midrst.err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 8'h0E);
        @(posedge clk);
        #1;
        chk("midrst.first_edge_r_valid", 32'(r_valid_o), 32'h0);
        @(negedge clk);
        model_reset();

        // Counter overflow then flush keeps the sticky error
        cycle_check("ovf1", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 4'h0, 1, 1'b0);
        cycle_check("ovf2", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'h0, 2, 1'b0);
        cycle_check("ovf3", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'h0, 3, 1'b0);
        cycle_check("ovf4", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'h0, 3, 1'b1);
        cycle_check("flush", 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1'b1);

        // Underflow: writeback with nothing pending
        do_reset();
        cycle_check("udf", 1'b0, 1'b1, 1'b0, 4'b1010, 2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 4'b1010, 0, 1'b1);

        do_reset();
        for (int i = 0; i < 400; i++)
            model_check($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                        ($urandom_range(0, 19) == 0), 4'($urandom), 2'($urandom), 8'($urandom));

        do_reset();
        pc[0] = 0; pc[1] = 0;
        for (int nz = 0; nz < 16; nz++) begin
            model_check($sformatf("sweep_set%0d", nz), 1'b0, 1'b1, 1'b0, 4'(nz), 2'b00, 8'h00);
            for (int c = 0; c < 16; c++) begin
                model_check($sformatf("sweep_f%0d_c%0d", nz, c), 1'b0, 1'b0, 1'b0, 4'h0, 2'b11,
                            {4'(15 - c), 4'(c)});
                pc[0] += int'(ref_pass(4'(c), 4'(nz)));
                pc[1] += int'(ref_pass(4'(15 - c), 4'(nz)));
            end
        end
`ifdef COND_PERF_EN
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("perf_total%0d", k),
                32'(perf_pass_o[16*k +: 16]) + 32'(perf_fail_o[16*k +: 16]), 32'd256);
            chk($sformatf("perf_pass%0d", k), 32'(perf_pass_o[16*k +: 16]), 32'(pc[k]));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
